lc3_execute_mc: RTL and testbench

// - Parametrised next-generation LC-3 execute stage. Sits between decode/register-file read and the memory stage.
// - Adds operand bypass muxes (ALU and memory forwarding) and a valid/ready handshake.
// - Adds an iterative multi-cycle MUL mode. Single-cycle ops behave as the current execute stage.

---
 rtl/lc3_exec_pkg.sv | 24 ++
 rtl/lc3_exec_mul.sv | 56 +++++
 rtl/lc3_execute_mc.sv | 186 ++++++++++++++++++
 tb/tb_lc3_execute_mc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_exec_pkg.sv
// Shared constants and types for the LC-3 execute stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lc3_exec_pkg;

  // ALU operation codes carried in alu_control
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_NOT  = 2'd2;
  localparam logic [1:0] ALU_XNOR = 2'd3;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int EC_ALU_LSB    = 4;
  localparam int EC_PCSEL1_LSB = 2;
  localparam int EC_PCSEL2     = 1;
  localparam int EC_OP2SEL     = 0;

  // Opcodes whose npc is adjusted before the target add
  localparam logic [3:0] OPC_BR  = 4'b0000;
  localparam logic [3:0] OPC_JMP = 4'b1100;

  typedef enum logic {IDLE, MUL} exec_state_t;

endpackage

// File: rtl/lc3_exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per non-held cycle, low DATA_W bits kept.
// Latency: DATA_W non-held cycles after start; done is a combinational strobe on the final step.
// Backpressure: hold freezes counter and partial product; start is ignored while a multiply runs.
module lc3_exec_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic              running;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] acc_nxt;

  // The final step's sum is presented directly so the caller can register it at the done edge
  assign acc_nxt = b_sh[0] ? (acc + a_sh) : acc;
  assign product = acc_nxt;
  assign done    = running & ~hold & (cnt == LAST);

  // Latch operands on start, then consume one multiplier bit per enabled cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        cnt     <= '0;
        acc     <= '0;
        a_sh    <= mcand;
        b_sh    <= mplier;
      end
    end else if (!hold) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/lc3_execute_mc.sv
// LC-3 execute stage: bypassed operands, ALU, address adder, NZP mask, optional iterative MUL.
// Latency: 1 cycle for single-cycle ops, DATA_W enabled cycles for MUL; out_valid pulses per result.
// Backpressure: in_ready drops for the whole MUL; enable_execute=0 stalls everything and holds outputs.
module lc3_execute_mc
  import lc3_exec_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter bit MUL_EN  = 1'b1,
  parameter int NPC_ADJ = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] npc,
  input  logic [5:0]        E_Control,
  input  logic              mul_op,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DATA_W-1:0] mem_bypass,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [2:0]        dr,
  output logic [DATA_W-1:0] aluout,
  output logic              alucarry,
  output logic [DATA_W-1:0] pcout,
  output logic [2:0]        NZP,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out,
  output logic [DATA_W-1:0] M_Data,
  output logic              out_valid,
  output logic              busy
);
  exec_state_t       state;
  logic [1:0]        alu_ctl;
  logic [1:0]        alu_op;
  logic [1:0]        pcsel1;
  logic              pcsel2;
  logic              op2sel;
  logic              is_mul;
  logic              is_brjmp;
  logic              accept;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] vsr2_byp;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] imm5;
  logic [DATA_W-1:0] off6;
  logic [DATA_W-1:0] off9;
  logic [DATA_W-1:0] off11;
  logic [DATA_W-1:0] addrin1;
  logic [DATA_W-1:0] addrin2;
  logic [DATA_W-1:0] pc_sum;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cy;
  logic [2:0]        nzp_d;
  logic [2:0]        dr_d;

  assign alu_ctl = E_Control[EC_ALU_LSB +: 2];
  assign pcsel1  = E_Control[EC_PCSEL1_LSB +: 2];
  assign pcsel2  = E_Control[EC_PCSEL2];
  assign op2sel  = E_Control[EC_OP2SEL];

  // Without the multiplier a MUL request degrades to an ADD of the same operands
  assign is_mul = MUL_EN & mul_op;
  assign alu_op = (mul_op && !MUL_EN) ? ALU_ADD : alu_ctl;

  assign busy     = (state == MUL);
  assign in_ready = ~busy;
  assign accept   = in_valid & in_ready & enable_execute;

  // Forwarding priority: previous ALU result, then memory stage, then register file
  assign op1      = bypass_alu_1 ? aluout : (bypass_mem_1 ? mem_bypass : VSR1);
  assign vsr2_byp = bypass_alu_2 ? aluout : (bypass_mem_2 ? mem_bypass : VSR2);
  assign op2      = op2sel ? vsr2_byp : imm5;

  assign imm5  = {{(DATA_W-5){IR[4]}},  IR[4:0]};
  assign off6  = {{(DATA_W-6){IR[5]}},  IR[5:0]};
  assign off9  = {{(DATA_W-9){IR[8]}},  IR[8:0]};
  assign off11 = {{(DATA_W-11){IR[10]}}, IR[10:0]};

  assign sr1 = IR[8:6];
  assign sr2 = (IR[13:12] == 2'b01) ? IR[2:0] : ((IR[13:12] == 2'b11) ? IR[11:9] : 3'b000);
  assign dr_d = (IR[13:12] == 2'b01 || IR[13:12] == 2'b10) ? IR[11:9] : 3'b000;

  assign is_brjmp = (IR[15:12] == OPC_BR) || (IR[15:12] == OPC_JMP);
  assign nzp_d    = (IR[15:12] == OPC_BR) ? IR[11:9] : ((IR[15:12] == OPC_JMP) ? 3'b111 : 3'b000);

  assign addrin2 = pcsel2 ? (is_brjmp ? (npc - DATA_W'(NPC_ADJ)) : npc) : op1;
  assign pc_sum  = addrin1 + addrin2;
  assign add_sum = {1'b0, op1} + {1'b0, op2};

  // Offset source for the address adder
  always_comb begin
    addrin1 = '0;
    case (pcsel1)
      2'd0:    addrin1 = off11;
      2'd1:    addrin1 = off9;
      2'd2:    addrin1 = off6;
      default: addrin1 = '0;
    endcase
  end

  // Single-cycle ALU; carry is meaningful only for ADD
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = add_sum[DATA_W-1:0];
        alu_cy  = add_sum[DATA_W];
      end
      ALU_AND: alu_res = op1 & op2;
      ALU_NOT: alu_res = ~op1;
      default: alu_res = ~(op1 ^ op2);
    endcase
  end

  lc3_exec_mul #(.DATA_W(DATA_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (accept & is_mul),
    .hold    (~enable_execute),
    .mcand   (op1),
    .mplier  (op2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM and result registers; side-band fields latch at accept even for MUL
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      dr              <= '0;
      aluout          <= '0;
      alucarry        <= 1'b0;
      pcout           <= '0;
      NZP             <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
      M_Data          <= '0;
      out_valid       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dr              <= dr_d;
            pcout           <= pc_sum;
            NZP             <= nzp_d;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
            M_Data          <= vsr2_byp;
            if (is_mul) begin
              state <= MUL;
            end else begin
              aluout    <= alu_res;
              alucarry  <= alu_cy;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            aluout    <= mul_product;
            alucarry  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_execute_mc.sv
// Directed bench for the LC-3 execute stage with hand-computed expectations.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises in_ready during MUL, stalls, and back-to-back accept.
module tb_lc3_execute_mc;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] IR;
  logic [15:0] npc;
  logic [5:0]  E_Control;
  logic        mul_op;
  logic [1:0]  W_Control_in;
  logic        Mem_Control_in;
  logic [15:0] VSR1, VSR2;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] mem_bypass;
  logic [2:0]  sr1, sr2, dr;
  logic [15:0] aluout;
  logic        alucarry;
  logic [15:0] pcout;
  logic [2:0]  NZP;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [15:0] M_Data;
  logic        out_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;
  int bad;

  lc3_execute_mc #(.DATA_W(16), .MUL_EN(1'b1), .NPC_ADJ(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable_execute  (enable_execute),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .IR              (IR),
    .npc             (npc),
    .E_Control       (E_Control),
    .mul_op          (mul_op),
    .W_Control_in    (W_Control_in),
    .Mem_Control_in  (Mem_Control_in),
    .VSR1            (VSR1),
    .VSR2            (VSR2),
    .bypass_alu_1    (bypass_alu_1),
    .bypass_alu_2    (bypass_alu_2),
    .bypass_mem_1    (bypass_mem_1),
    .bypass_mem_2    (bypass_mem_2),
    .mem_bypass      (mem_bypass),
    .sr1             (sr1),
    .sr2             (sr2),
    .dr              (dr),
    .aluout          (aluout),
    .alucarry        (alucarry),
    .pcout           (pcout),
    .NZP             (NZP),
    .W_Control_out   (W_Control_out),
    .Mem_Control_out (Mem_Control_out),
    .M_Data          (M_Data),
    .out_valid       (out_valid),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // E_Control builder: {alu, pcsel1, pcsel2, op2sel}
  function automatic logic [5:0] ec(input logic [1:0] alu, input logic [1:0] ps1,
                                    input logic ps2, input logic o2s);
    return {alu, ps1, ps2, o2s};
  endfunction

  initial begin
    reset = 1'b1; enable_execute = 1'b1; in_valid = 1'b0; IR = '0; npc = '0;
    E_Control = '0; mul_op = 1'b0; W_Control_in = '0; Mem_Control_in = 1'b0;
    VSR1 = '0; VSR2 = '0; bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0;
    bypass_mem_2 = 0; mem_bypass = '0;
    repeat (2) tick;

    // Reset state
    chk("rst_aluout", aluout, 0);
    chk("rst_pcout", pcout, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick;

    // ADD 3+4 register form; IR 0001 001 010 000 011
    IR = 16'h1283; E_Control = ec(2'd0, 2'd3, 1'b0, 1'b1); VSR1 = 16'd3; VSR2 = 16'd4;
    W_Control_in = 2'b10; Mem_Control_in = 1'b1; in_valid = 1'b1;
    #1;
    chk("sr1", sr1, 3'd2);
    chk("sr2", sr2, 3'd3);
    tick;
    in_valid = 1'b0;
    chk("add_aluout", aluout, 16'd7);
    chk("add_carry", alucarry, 0);
    chk("add_valid", out_valid, 1);
    chk("add_dr", dr, 3'd1);
    chk("add_mdata", M_Data, 16'd4);
    chk("add_pcout", pcout, 16'd3);
    chk("add_wctl", W_Control_out, 2'b10);
    chk("add_memctl", Mem_Control_out, 1);
    tick;
    chk("add_pulse", out_valid, 0);
    chk("add_hold", aluout, 16'd7);

    // ADD immediate with carry out: FFFF + 1
    IR = 16'h1021; E_Control = ec(2'd0, 2'd3, 1'b0, 1'b0); VSR1 = 16'hFFFF; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("carry_aluout", aluout, 16'h0000);
    chk("carry_bit", alucarry, 1);

    // Bypass priority: prime aluout=5 first
    IR = 16'h1283; E_Control = ec(2'd0, 2'd3, 1'b0, 1'b1); VSR1 = 16'd2; VSR2 = 16'd3; in_valid = 1'b1;
    tick;
    chk("prime_aluout", aluout, 16'd5);
    IR = 16'h1020; E_Control = ec(2'd0, 2'd3, 1'b0, 1'b0); VSR1 = 16'd1; mem_bypass = 16'd9;
    bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1;
    tick;
    chk("byp_alu_over_mem", aluout, 16'd5);
    bypass_alu_1 = 1'b0;
    tick;
    chk("byp_mem_over_vsr", aluout, 16'd9);
    bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b1; VSR2 = 16'd100;
    E_Control = ec(2'd0, 2'd3, 1'b0, 1'b1);
    tick;
    chk("byp_op2_mem", aluout, 16'd10);
    chk("byp_mdata", M_Data, 16'd9);
    bypass_mem_2 = 1'b0;

    // AND, NOT, XNOR with 0F0F / 00FF
    VSR1 = 16'h0F0F; VSR2 = 16'h00FF;
    E_Control = ec(2'd1, 2'd3, 1'b0, 1'b1);
    tick;
    chk("and", aluout, 16'h000F);
    E_Control = ec(2'd2, 2'd3, 1'b0, 1'b1);
    tick;
    chk("not", aluout, 16'hF0F0);
    chk("not_carry", alucarry, 0);
    E_Control = ec(2'd3, 2'd3, 1'b0, 1'b1);
    tick;
    chk("xnor", aluout, 16'hF00F);

    // BR nzp=111 off9=5 with npc adjust: 3001-1+5
    IR = 16'h0E05; npc = 16'h3001; E_Control = ec(2'd0, 2'd1, 1'b1, 1'b0);
    tick;
    chk("br_pcout", pcout, 16'h3005);
    chk("br_nzp", NZP, 3'b111);
    chk("br_dr", dr, 3'd0);
    // JMP: zero offset, npc adjusted, NZP forced to 111
    IR = 16'hC1C0; E_Control = ec(2'd0, 2'd3, 1'b1, 1'b0);
    tick;
    chk("jmp_pcout", pcout, 16'h3000);
    chk("jmp_nzp", NZP, 3'b111);
    // JSR-style off11=-2 with unadjusted npc
    IR = 16'h4FFE; E_Control = ec(2'd0, 2'd0, 1'b1, 1'b0);
    tick;
    chk("off11_pcout", pcout, 16'h2FFF);
    chk("off11_nzp", NZP, 3'b000);
    // LDR-style base+off6 (-1), dr from IR[11:9]
    IR = 16'h6A3F; VSR1 = 16'h1000; E_Control = ec(2'd0, 2'd2, 1'b0, 1'b0);
    tick;
    in_valid = 1'b0;
    chk("off6_pcout", pcout, 16'h0FFF);
    chk("off6_dr", dr, 3'd5);

    // MUL 6*7 with an ADD 10+20 held upstream while busy
    IR = 16'h1283; E_Control = ec(2'd0, 2'd3, 1'b0, 1'b1); VSR1 = 16'd6; VSR2 = 16'd7;
    mul_op = 1'b1; in_valid = 1'b1;
    tick;
    mul_op = 1'b0; VSR1 = 16'd10; VSR2 = 16'd20;
    n = 0; bad = 0;
    while (!out_valid && n < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick;
      n++;
    end
    chk("mul_latency", n, 16);
    chk("mul_ready_low", bad, 0);
    chk("mul_result", aluout, 16'd42);
    chk("mul_carry", alucarry, 0);
    chk("mul_done_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", aluout, 16'd30);

    // MUL 1000*70 with a 3-cycle stall mid-op; 70000 mod 65536 = 4464
    VSR1 = 16'd1000; VSR2 = 16'd70; mul_op = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; mul_op = 1'b0;
    n = 0; bad = 0;
    while (!out_valid && n < 100) begin
      enable_execute = (n >= 5 && n < 8) ? 1'b0 : 1'b1;
      tick;
      n++;
    end
    enable_execute = 1'b1;
    chk("stall_latency", n, 19);
    chk("stall_result", aluout, 16'h1170);

    // Reset mid-MUL after 8 enabled steps
    VSR1 = 16'd6; VSR2 = 16'd7; mul_op = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; mul_op = 1'b0;
    repeat (8) tick;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_aluout", aluout, 0);
    chk("midrst_pcout", pcout, 0);
    chk("midrst_dr", dr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst_no_valid", bad, 0);

    // Normal ADD after the aborted multiply
    VSR1 = 16'd3; VSR2 = 16'd4; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("post_rst_add", aluout, 16'd7);
    chk("post_rst_valid", out_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
